// File: rtl/fp_norm_lzc_pipe_if.sv
// Handshake bundle for the normalisation stage: upstream mantissa/exponent in,
// shifter control plus adjusted exponent out.
interface fp_norm_lzc_pipe_if #(
  parameter int unsigned MW = 25,
  parameter int unsigned EW = 8,
  parameter int unsigned SW = 5
);
  logic          in_valid;
  logic          in_ready;
  logic          in_sign;
  logic [EW-1:0] in_exp;
  logic [MW-1:0] in_mant;

  logic          out_valid;
  logic          out_ready;
  logic          out_sign;
  logic [EW-1:0] out_exp;
  logic [MW-1:0] out_mant;
  logic [SW-1:0] out_shamt;
  logic          out_zero;
  logic          out_denorm;

  // Master drives the input bundle and consumes the output bundle.
  modport master (
    output in_valid, in_sign, in_exp, in_mant, out_ready,
    input  in_ready, out_valid, out_sign, out_exp, out_mant, out_shamt, out_zero, out_denorm
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, out_ready,
    output in_ready, out_valid, out_sign, out_exp, out_mant, out_shamt, out_zero, out_denorm
  );
endinterface

// File: rtl/fp_norm_lzc_pipe.sv
// Two-stage normalisation control: leading-zero count, shift select and exponent
// adjustment with denormal clamp, feeding the 25-bit left barrel shifter.
module fp_norm_lzc_pipe #(
  parameter int unsigned MW = 25,
  parameter int unsigned EW = 8
) (
  input logic              clk,
  input logic              rst_n,
  fp_norm_lzc_pipe_if.slave bus
);
  localparam int unsigned SW = 5;

  logic          s1_valid_q;
  logic          s1_sign_q;
  logic [EW-1:0] s1_exp_q;
  logic [MW-1:0] s1_mant_q;

  logic          out_valid_q;
  logic          out_sign_q;
  logic [EW-1:0] out_exp_q;
  logic [MW-1:0] out_mant_q;
  logic [SW-1:0] out_shamt_q;
  logic          out_zero_q;
  logic          out_denorm_q;

  logic          s2_free;
  logic          s1_load;
  logic          s1_move;

  logic [SW-1:0] lz;
  logic          lz_found;
  logic [EW-1:0] lz_ext;
  logic [EW-1:0] exp_m1;
  logic [EW-1:0] out_exp_d;
  logic [SW-1:0] out_shamt_d;
  logic          out_zero_d;
  logic          out_denorm_d;

  assign s2_free      = !out_valid_q || bus.out_ready;
  assign bus.in_ready = !s1_valid_q || s2_free;
  assign s1_load      = bus.in_valid && bus.in_ready;
  assign s1_move      = s1_valid_q && s2_free;

  // Priority scan from the MSB; an all-zero mantissa leaves lz at MW.
  always_comb begin
    lz       = SW'(MW);
    lz_found = 1'b0;
    for (int i = int'(MW) - 1; i >= 0; i--) begin
      if (!lz_found && s1_mant_q[i]) begin
        lz       = SW'(int'(MW) - 1 - i);
        lz_found = 1'b1;
      end
    end
  end

  assign lz_ext = {{(EW-SW){1'b0}}, lz};
  assign exp_m1 = s1_exp_q - EW'(1);

  always_comb begin
    out_exp_d    = '0;
    out_shamt_d  = '0;
    out_zero_d   = 1'b0;
    out_denorm_d = 1'b0;
    if (s1_mant_q == '0) begin
      out_zero_d = 1'b1;
    end else if (s1_exp_q > lz_ext) begin
      out_shamt_d = lz;
      out_exp_d   = s1_exp_q - lz_ext;
    end else begin
      // Shift only as far as the exponent allows; result lands at the denormal position.
      out_shamt_d  = (s1_exp_q == '0) ? '0 : exp_m1[SW-1:0];
      out_denorm_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_exp_q   <= '0;
      s1_mant_q  <= '0;
    end else begin
      if (s1_load) begin
        s1_valid_q <= 1'b1;
        s1_sign_q  <= bus.in_sign;
        s1_exp_q   <= bus.in_exp;
        s1_mant_q  <= bus.in_mant;
      end else if (s1_move) begin
        s1_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_sign_q   <= 1'b0;
      out_exp_q    <= '0;
      out_mant_q   <= '0;
      out_shamt_q  <= '0;
      out_zero_q   <= 1'b0;
      out_denorm_q <= 1'b0;
    end else if (s2_free) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_sign_q   <= s1_sign_q;
        out_exp_q    <= out_exp_d;
        out_mant_q   <= s1_mant_q;
        out_shamt_q  <= out_shamt_d;
        out_zero_q   <= out_zero_d;
        out_denorm_q <= out_denorm_d;
      end
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_sign   = out_sign_q;
  assign bus.out_exp    = out_exp_q;
  assign bus.out_mant   = out_mant_q;
  assign bus.out_shamt  = out_shamt_q;
  assign bus.out_zero   = out_zero_q;
  assign bus.out_denorm = out_denorm_q;

endmodule

// File: tb/tb_fp_norm_lzc_pipe.sv
// Self-checking bench for fp_norm_lzc_pipe: directed cases plus randomized
// handshake traffic scored against a behavioural normalisation model.
module tb_fp_norm_lzc_pipe;
  localparam int MW = 25;
  localparam int EW = 8;

  typedef struct packed {
    logic          sign;
    logic [EW-1:0] exp;
    logic [MW-1:0] mant;
    logic [4:0]    shamt;
    logic          zero;
    logic          denorm;
  } res_t;

  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  res_t exp_q[$];

  fp_norm_lzc_pipe_if #(.MW(MW), .EW(EW)) bus ();

  fp_norm_lzc_pipe #(.MW(MW), .EW(EW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: bit length of the mantissa gives the leading-zero count directly.
  function automatic res_t model(input logic s, input logic [EW-1:0] e, input logic [MW-1:0] m);
    res_t r;
    int len = 0;
    int lz;
    logic [MW-1:0] t = m;
    while (t != 0) begin
      t = t >> 1;
      len++;
    end
    lz = MW - len;
    r.sign = s;
    r.mant = m;
    r.zero = 1'b0;
    r.denorm = 1'b0;
    if (m == 0) begin
      r.shamt = 5'd0;
      r.exp   = '0;
      r.zero  = 1'b1;
    end else if (int'(e) > lz) begin
      r.shamt = 5'(lz);
      r.exp   = EW'(int'(e) - lz);
    end else begin
      r.shamt  = (e == 0) ? 5'd0 : 5'(int'(e) - 1);
      r.exp    = '0;
      r.denorm = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [MW-1:0] rand_mant();
    logic [MW-1:0] m;
    m = MW'($urandom);
    return m >> $urandom_range(0, MW);
  endfunction

  function automatic logic [EW-1:0] rand_exp();
    if ($urandom_range(0, 3) == 0) return EW'($urandom);
    return EW'($urandom_range(0, 30));
  endfunction

  // One clock: drive at negedge, sample 1 time unit later, then advance to posedge.
  task automatic step(input bit v, input logic s, input logic [EW-1:0] e,
                      input logic [MW-1:0] m, input bit rdy,
                      output bit ir, output bit ov, output res_t o);
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_sign   = s;
    bus.in_exp    = e;
    bus.in_mant   = m;
    bus.out_ready = rdy;
    #1;
    ir = bus.in_ready;
    ov = bus.out_valid;
    o  = '{sign: bus.out_sign, exp: bus.out_exp, mant: bus.out_mant,
           shamt: bus.out_shamt, zero: bus.out_zero, denorm: bus.out_denorm};
    if (v && ir) exp_q.push_back(model(s, e, m));
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    bit ir, ov;
    res_t o;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 1'b1, ir, ov, o);
  endtask

  // Push one item into an empty pipe; report out_valid one and two cycles after accept.
  task automatic run_one(input logic s, input logic [EW-1:0] e, input logic [MW-1:0] m,
                         output bit acc, output bit ov_early, output bit ov_on, output res_t o);
    bit ir;
    bit ov;
    res_t tmp;
    idle(3);
    exp_q.delete();
    step(1'b1, s, e, m, 1'b1, acc, ov, tmp);
    step(1'b0, 1'b0, '0, '0, 1'b1, ir, ov_early, tmp);
    step(1'b0, 1'b0, '0, '0, 1'b1, ir, ov_on, o);
    exp_q.delete();
  endtask

  task automatic test_reset();
    bit ir, ov;
    res_t o;
    logic [MW+EW+10:0] all_out;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: in_ready=%0b out_valid=%0b, want 1/0",
               bus.in_ready, bus.out_valid);
    end
    // Fill both stages, then reset asynchronously between edges.
    step(1'b1, 1'b1, 8'd50, 25'h0F0F0F0, 1'b0, ir, ov, o);
    step(1'b1, 1'b1, 8'd60, 25'h1234567, 1'b0, ir, ov, o);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_prefill: out_valid=%0b in_ready=%0b, want 1/0",
               bus.out_valid, bus.in_ready);
    end
    rst_n = 1'b0;
    #1;
    all_out = {bus.out_valid, bus.out_sign, bus.out_exp, bus.out_mant, bus.out_shamt,
               bus.out_zero, bus.out_denorm};
    n_tests++;
    if (all_out !== '0) begin
      n_fail++;
      $display("FAIL reset_async_outputs: got %h, want 0", all_out);
    end
    n_tests++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_async_in_ready: got %0b, want 1", bus.in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, '0, '0, 1'b1, ir, ov, o);
      n_tests++;
      if (ov !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_no_replay: cycle %0d out_valid=%0b, want 0", i, ov);
      end
    end
  endtask

  task automatic test_normal();
    bit acc, ov_e, ov_on;
    res_t o, want;
    run_one(1'b1, 8'd100, 25'h0001000, acc, ov_e, ov_on, o);
    n_tests++;
    if ({acc, ov_e, ov_on} !== 3'b101) begin
      n_fail++;
      $display("FAIL normal_latency: accept/early/on=%b, want 101", {acc, ov_e, ov_on});
    end
    want = '{sign: 1'b1, exp: 8'd88, mant: 25'h0001000, shamt: 5'd12, zero: 1'b0, denorm: 1'b0};
    n_tests++;
    if (o !== want) begin
      n_fail++;
      $display("FAIL normal_fields: got %h, want %h", o, want);
    end
  endtask

  task automatic test_norm_zero();
    bit acc, ov_e, ov_on;
    res_t o, want;
    run_one(1'b0, 8'd5, 25'h1000000, acc, ov_e, ov_on, o);
    want = '{sign: 1'b0, exp: 8'd5, mant: 25'h1000000, shamt: 5'd0, zero: 1'b0, denorm: 1'b0};
    n_tests++;
    if (!ov_on || o !== want) begin
      n_fail++;
      $display("FAIL already_normal: valid=%0b got %h, want %h", ov_on, o, want);
    end
    run_one(1'b1, 8'd77, 25'h0, acc, ov_e, ov_on, o);
    want = '{sign: 1'b1, exp: 8'd0, mant: 25'h0, shamt: 5'd0, zero: 1'b1, denorm: 1'b0};
    n_tests++;
    if (!ov_on || o !== want) begin
      n_fail++;
      $display("FAIL zero_mant: valid=%0b got %h, want %h", ov_on, o, want);
    end
  endtask

  task automatic test_underflow();
    bit acc, ov_e, ov_on;
    res_t o, want;
    logic [EW-1:0] exps[4] = '{8'd6, 8'd0, 8'd20, 8'd21};
    logic [4:0]    shs[4]  = '{5'd5, 5'd0, 5'd19, 5'd20};
    logic [EW-1:0] oex[4]  = '{8'd0, 8'd0, 8'd0, 8'd1};
    logic          dns[4]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    // lz=20: exp 6 and 0 underflow, exp==lz is the last clamped case, exp==lz+1 is normal.
    for (int i = 0; i < 4; i++) begin
      run_one(1'b0, exps[i], 25'h0000010, acc, ov_e, ov_on, o);
      want = '{sign: 1'b0, exp: oex[i], mant: 25'h0000010, shamt: shs[i], zero: 1'b0,
               denorm: dns[i]};
      n_tests++;
      if (!ov_on || o !== want) begin
        n_fail++;
        $display("FAIL underflow_exp%0d: valid=%0b got %h, want %h", exps[i], ov_on, o, want);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ir, ov;
    res_t o, held, want;
    logic [MW-1:0] ms[4] = '{25'h0800000, 25'h0000003, 25'h0, 25'h00ABCDE};
    logic [EW-1:0] es[4] = '{8'd9, 8'd30, 8'd12, 8'd3};
    int idx = 0;
    int got = 0;
    idle(3);
    exp_q.delete();
    for (int c = 0; c < 3; c++) begin
      step(idx < 4, idx[0], es[idx % 4], ms[idx % 4], 1'b0, ir, ov, o);
      if (c == 2) begin
        n_tests++;
        if (ir !== 1'b0 || idx != 2) begin
          n_fail++;
          $display("FAIL bp_in_ready_drop: in_ready=%0b accepts=%0d, want 0/2", ir, idx);
        end
        held = o;
      end
      if (idx < 4 && ir) idx++;
    end
    for (int c = 0; c < 50 && got < 4; c++) begin
      step(idx < 4, idx[0], es[idx % 4], ms[idx % 4], 1'b1, ir, ov, o);
      if (c == 0) begin
        n_tests++;
        if (ov !== 1'b1 || o !== held) begin
          n_fail++;
          $display("FAIL bp_stable: valid=%0b got %h, want %h", ov, o, held);
        end
      end
      if (idx < 4 && ir) idx++;
      if (ov) begin
        want = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        n_tests++;
        if (o !== want) begin
          n_fail++;
          $display("FAIL bp_order_item%0d: got %h, want %h", got, o, want);
        end
        got++;
      end
    end
    idle(2);
    n_tests++;
    if (got != 4 || exp_q.size() != 0 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_count: got %0d left %0d valid %0b, want 4/0/0",
               got, exp_q.size(), bus.out_valid);
    end
  endtask

  task automatic test_throughput();
    bit ir, ov, v, rdy, hold;
    res_t o, held, want;
    logic s;
    logic [EW-1:0] e;
    logic [MW-1:0] m;
    int sent = 0;
    int recv = 0;
    hold = 1'b0;
    held = '0;
    idle(3);
    exp_q.delete();
    s = 1'($urandom); e = rand_exp(); m = rand_mant();
    for (int c = 0; c < 60000 && recv < 10000; c++) begin
      v   = (sent < 10000) && ($urandom_range(0, 99) < 70);
      rdy = $urandom_range(0, 99) < 70;
      step(v, s, e, m, rdy, ir, ov, o);
      if (hold) begin
        n_tests++;
        if (ov !== 1'b1 || o !== held) begin
          n_fail++;
          $display("FAIL rand_stall_stable: cycle %0d valid=%0b got %h, want %h",
                   c, ov, o, held);
        end
      end
      if (v && ir) begin
        sent++;
        s = 1'($urandom); e = rand_exp(); m = rand_mant();
      end
      if (ov && rdy) begin
        want = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        n_tests++;
        if (o !== want) begin
          n_fail++;
          $display("FAIL rand_item%0d: got %h, want %h", recv, o, want);
        end
        recv++;
      end
      hold = ov && !rdy;
      held = o;
    end
    n_tests++;
    if (recv != 10000) begin
      n_fail++;
      $display("FAIL rand_complete: received %0d, want 10000", recv);
    end
    // Both ends always ready: one accept and, after fill, one output every cycle.
    idle(3);
    exp_q.delete();
    for (int c = 0; c < 203; c++) begin
      v = c < 200;
      step(v, 1'($urandom), rand_exp(), rand_mant(), 1'b1, ir, ov, o);
      n_tests++;
      if ((v && !ir) || ov !== (c >= 2 && c <= 201)) begin
        n_fail++;
        $display("FAIL full_rate_cycle%0d: in_ready=%0b out_valid=%0b", c, ir, ov);
      end
      if (ov) begin
        want = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        n_tests++;
        if (o !== want) begin
          n_fail++;
          $display("FAIL full_rate_item%0d: got %h, want %h", c, o, want);
        end
      end
    end
  endtask

  initial begin
    rst_n         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_sign   = 1'b0;
    bus.in_exp    = '0;
    bus.in_mant   = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_normal();
    test_norm_zero();
    test_underflow();
    test_backpressure();
    test_throughput();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fp_norm_lzc_pipe.md
Name: fp_norm_lzc_pipe

Overview:
- Normalisation control stage directly upstream of the 25-bit left barrel shifter in the FPAU square-root datapath.
- Accepts an unnormalised 25-bit mantissa with sign and biased exponent, and counts its leading zeros.
- Produces the 5-bit shift select for the shifter and the exponent adjusted for that shift; handles zero and underflow (denormal clamp).
- Two-stage pipeline with valid/ready handshakes on both sides and full throughput.

Parameters:
- MW, 25, mantissa width; must match the shifter width. Shift select is 5 bits.
- EW, 8, biased exponent width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream data valid.
- in_ready  output  1  block can accept this cycle.
- in_sign  input  1  sign bit; passed through unchanged.
- in_exp  input  EW  biased exponent.
- in_mant  input  MW  unnormalised mantissa; bit MW-1 is the normalised MSB position.
- out_valid  output  1  output bundle valid.
- out_ready  input  1  downstream accepts this cycle.
- out_sign  output  1  registered sign.
- out_exp  output  EW  adjusted exponent.
- out_mant  output  MW  unshifted mantissa, aligned with out_shamt; drives the shifter data input.
- out_shamt  output  5  left-shift amount; drives the shifter select.
- out_zero  output  1  mantissa was all zero.
- out_denorm  output  1  shift was clamped by the exponent (underflow).

Behaviour:
- Reset (async, rst_n=0):
  - s1_valid=0, out_valid=0.
  - out_sign=0, out_exp=0, out_mant=0, out_shamt=0, out_zero=0, out_denorm=0.
  - Stage-1 data registers cleared to 0.
  - Reset mid-transfer discards all in-flight data; nothing is replayed.
- Handshakes:
  - Transfer occurs when valid and ready are both high in the same cycle.
  - s2_free = !out_valid | out_ready.
  - in_ready = !s1_valid | s2_free. in_ready is combinational from out_ready; there is no path from in_valid to in_ready.
  - Once asserted, out_valid holds and out_* stay stable until out_ready is seen.
- Stage 1: on an in_valid & in_ready transfer, register sign, exp and mant, and set s1_valid=1.
  - If in_ready is high with no new input, s1_valid clears when stage 1 moves its data forward.
  - A simultaneous accept into stage 1 and move from stage 1 to stage 2 is legal: stage 1 reloads and stays valid.
- Stage 2: when s1_valid & s2_free, compute from the stage-1 registers and load the outputs; out_valid=1.
  - If s2_free and !s1_valid, out_valid goes to 0.
  - Latency: 2 cycles from input accept to out_valid with no stall. Throughput: 1 per cycle.
- Leading-zero count: lz = number of leading zeros of s1_mant, range 0..25. Output fields by case:
  - Zero case, s1_mant==0: out_shamt=0, out_exp=0, out_zero=1, out_denorm=0.
  - Normal case, s1_exp > lz: out_shamt=lz, out_exp=s1_exp-lz, out_denorm=0.
  - Underflow case, s1_exp <= lz and s1_mant!=0:
    - out_shamt = (s1_exp==0) ? 0 : s1_exp-1; out_exp=0; out_denorm=1.
    - The shifter then places the value at the denormal position.
  - In all cases out_mant=s1_mant and out_sign=s1_sign.
- Width rules:
  - lz <= 24 whenever the mantissa is nonzero, so out_shamt always fits in 5 bits. Values 25..31 are never produced.
  - The exponent subtraction is unsigned EW-bit and is evaluated only in the normal case, so it never wraps.
- Stall: with out_ready=0, at most two items are held (stage 1 and output). in_ready drops once both are occupied.

Test Plan:
1. Reset/idle: assert rst_n=0 mid-stream -> out_valid=0 and all outputs 0 immediately (asynchronously); in_ready=1 after release.
2. Normal: mant=25'h0001000 (lz=12), exp=100, out_ready=1 -> two cycles later out_shamt=12, out_exp=88, out_zero=0, out_denorm=0.
3. Already normalised and zero: mant=25'h1000000, exp=5 -> shamt=0, exp=5. Then mant=0, exp=77 -> zero=1, exp=0, shamt=0.
4. Underflow: mant=25'h0000010 (lz=20), exp=6 -> shamt=5, exp=0, denorm=1. Same mant with exp=0 -> shamt=0, denorm=1.
5. Backpressure: stream 4 items with out_ready low for 3 cycles -> in_ready drops after 2 accepts; order preserved; no loss or duplication; outputs stable while stalled.
6. Throughput: random in_valid/out_ready over 10k items -> scoreboard matches the reference model; one transfer per cycle when both ends are always ready.
